// File: rtl/mem_access_stage_pkg.sv
// mem_stage_pkg: shared definitions for the memory-access stage.
//   - size encodings SZ_BYTE / SZ_HALF / SZ_WORD (2'b11 is handled as word)
//   - FSM state enum state_t
//   - helpers: byte_en (lane enables), misaligned (alignment check),
//     store_lanes (lane replication of LSB-aligned store data)
package mem_stage_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_R
    } state_t;

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: byte_en = 4'b0001 << lo;
            SZ_HALF: byte_en = lo[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = lo[0];
            default: misaligned = (lo != 2'b00);
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_BYTE: store_lanes = {4{wdata[7:0]}};
            SZ_HALF: store_lanes = {2{wdata[15:0]}};
            default: store_lanes = wdata;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: data-memory bus between the memory-access stage
// (master) and the memory / interconnect (slave).
//   req, we, addr[29:0] (word address), be[3:0], wdata[31:0] : master -> slave
//   gnt, rvalid, rdata[31:0]                                 : slave -> master
interface mem_access_stage_if;

    logic        req;
    logic        we;
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/mem_access_stage_load_extend.sv
// load_extend: combinational load-data formatting.
//   rdata[31:0] : word returned by the bus
//   addr[1:0]   : byte offset of the access
//   size[1:0]   : SZ_BYTE / SZ_HALF / word
//   uns         : 1 = zero-extend, 0 = sign-extend
//   result[31:0]: selected lane, extended to 32 bits (words pass through)
module load_extend
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        case (addr)
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        lane_h = addr[1] ? rdata[31:16] : rdata[15:0];

        case (size)
            SZ_BYTE: result = {{24{~uns & lane_b[7]}}, lane_b};
            SZ_HALF: result = {{16{~uns & lane_h[15]}}, lane_h};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: load/store unit between EX and the write-back selector.
//   clk, rst_n (async, active low)
//   ex_*     : operation from EX; ex_ready high only in IDLE
//   bus      : mem_access_stage_if.master request/grant/response bus
//   wb_valid : one-cycle completion pulse; wb_data = extended load data
//              (0 for stores/errors); wb_err = misaligned or timeout
// Optional: define LSU_TIMEOUT_EN to abort a bus wait after TIMEOUT_CYCLES.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ex_valid,
    output logic               ex_ready,
    input  logic               ex_mem_read,
    input  logic               ex_mem_write,
    input  logic [1:0]         ex_size,
    input  logic               ex_unsigned,
    input  logic [31:0]        ex_addr,
    input  logic [31:0]        ex_wdata,
    mem_access_stage_if.master bus,
    output logic               wb_valid,
    output logic [31:0]        wb_data,
    output logic               wb_err
);

    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    state_t      state_q, state_d;
    logic        accept, misalign, expired;
    logic        we_q, uns_q;
    logic [29:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q, lane_q;
    logic [31:0] ext_data;
    logic        wb_valid_d, wb_err_d;
    logic [31:0] wb_data_d;

    assign accept   = ex_valid & ex_ready & (ex_mem_read | ex_mem_write);
    assign misalign = misaligned(ex_size, ex_addr[1:0]);

`ifdef LSU_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    // Held at zero while idle, so the count starts at 0 on the first REQ cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  tmo_cnt <= '0;
        else if (state_q == ST_IDLE) tmo_cnt <= '0;
        else                         tmo_cnt <= tmo_cnt + 16'd1;
    end

    assign expired = (tmo_cnt == 16'(TIMEOUT_CYCLES));
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Grant / rvalid are tested before the timeout so a completion on the
    // limit cycle wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept && !misalign) state_d = ST_REQ;
            ST_REQ:    if (bus.gnt)      state_d = we_q ? ST_IDLE : ST_WAIT_R;
                       else if (expired) state_d = ST_IDLE;
            ST_WAIT_R: if (bus.rvalid || expired) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ex_ready   = (state_q == ST_IDLE);
        wb_valid_d = 1'b0;
        wb_err_d   = 1'b0;
        wb_data_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept && misalign) begin
                    wb_valid_d = 1'b1;
                    wb_err_d   = 1'b1;
                end
            end
            ST_REQ: begin
                if (bus.gnt) begin
                    wb_valid_d = we_q;
                end else if (expired) begin
                    wb_valid_d = 1'b1;
                    wb_err_d   = 1'b1;
                end
            end
            ST_WAIT_R: begin
                if (bus.rvalid) begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = ext_data;
                end else if (expired) begin
                    wb_valid_d = 1'b1;
                    wb_err_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.req   = (state_q == ST_REQ);
    assign bus.we    = we_q;
    assign bus.addr  = addr_q;
    assign bus.be    = be_q;
    assign bus.wdata = wdata_q;

    // Read wins when both read and write are flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            size_q  <= SZ_BYTE;
            lane_q  <= '0;
            uns_q   <= 1'b0;
        end else if (accept && !misalign) begin
            we_q    <= ~ex_mem_read;
            addr_q  <= ex_addr[31:2];
            be_q    <= byte_en(ex_size, ex_addr[1:0]);
            wdata_q <= ex_mem_read ? '0 : store_lanes(ex_size, ex_wdata);
            size_q  <= ex_size;
            lane_q  <= ex_addr[1:0];
            uns_q   <= ex_unsigned;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_err   <= 1'b0;
            wb_data  <= '0;
        end else begin
            wb_valid <= wb_valid_d;
            wb_err   <= wb_err_d;
            wb_data  <= wb_data_d;
        end
    end

    load_extend u_load_extend (
        .rdata  (bus.rdata),
        .addr   (lane_q),
        .size   (size_q),
        .uns    (uns_q),
        .result (ext_data)
    );

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed scoreboard bench for mem_access_stage.
// Expected write-back results are queued when an operation is issued and a
// monitor pops/compares them on every wb_valid pulse. Define LSU_TIMEOUT_EN
// to also exercise the bus-wait abort (TIMEOUT_CYCLES = 4).
module tb_mem_access_stage;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        ex_valid, ex_ready, ex_mem_read, ex_mem_write, ex_unsigned;
    logic [1:0]  ex_size;
    logic [31:0] ex_addr, ex_wdata;
    logic        wb_valid, wb_err;
    logic [31:0] wb_data;

    mem_access_stage_if bus ();

    mem_access_stage #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_size      (ex_size),
        .ex_unsigned  (ex_unsigned),
        .ex_addr      (ex_addr),
        .ex_wdata     (ex_wdata),
        .bus          (bus),
        .wb_valid     (wb_valid),
        .wb_data      (wb_data),
        .wb_err       (wb_err)
    );

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic prev_wb = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n && wb_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_wb: wb_valid with nothing outstanding (data %h err %b)",
                         wb_data, wb_err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wb_data", wb_data, e.data);
                check("wb_err", {31'b0, wb_err}, {31'b0, e.err});
            end
            check("wb_single_pulse", {31'b0, prev_wb}, 32'd0);
        end
        prev_wb = wb_valid;
    end

    task automatic expect_wb(input logic [31:0] d, input logic e);
        exp_t x;
        x.data = d;
        x.err  = e;
        exp_q.push_back(x);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) break;
        end
        check(name, exp_q.size(), 32'd0);
    endtask

    task automatic drive_op(input logic rd, input logic wr, input logic [1:0] sz,
                            input logic uns, input logic [31:0] a, input logic [31:0] wd);
        ex_valid     = 1'b1;
        ex_mem_read  = rd;
        ex_mem_write = wr;
        ex_size      = sz;
        ex_unsigned  = uns;
        ex_addr      = a;
        ex_wdata     = wd;
    endtask

    // Called at the negedge following the accepting posedge.
    task automatic load_phase(input string tag, input logic [29:0] ea, input logic [3:0] ebe,
                              input int unsigned gw, input int unsigned rw, input logic [31:0] rd);
        ex_valid = 1'b0;
        check({tag, "_req"},  {31'b0, bus.req}, 32'd1);
        check({tag, "_we"},   {31'b0, bus.we},  32'd0);
        check({tag, "_addr"}, {2'b0, bus.addr}, {2'b0, ea});
        check({tag, "_be"},   {28'b0, bus.be},  {28'b0, ebe});
        for (int i = 0; i < int'(gw); i++) begin
            @(negedge clk);
            check({tag, "_req_hold"}, {31'b0, bus.req}, 32'd1);
        end
        bus.gnt = 1'b1;
        @(negedge clk);
        bus.gnt = 1'b0;
        check({tag, "_req_drop"}, {31'b0, bus.req}, 32'd0);
        for (int i = 0; i < int'(rw); i++) @(negedge clk);
        bus.rvalid = 1'b1;
        bus.rdata  = rd;
        @(negedge clk);
        bus.rvalid = 1'b0;
        bus.rdata  = '0;
        drain({tag, "_drain"});
    endtask

    task automatic store_phase(input string tag, input logic [29:0] ea, input logic [3:0] ebe,
                               input logic [31:0] ewd, input int unsigned gw);
        ex_valid = 1'b0;
        for (int i = 0; i <= int'(gw); i++) begin
            if (i > 0) @(negedge clk);
            check({tag, "_req"},   {31'b0, bus.req}, 32'd1);
            check({tag, "_we"},    {31'b0, bus.we},  32'd1);
            check({tag, "_addr"},  {2'b0, bus.addr}, {2'b0, ea});
            check({tag, "_be"},    {28'b0, bus.be},  {28'b0, ebe});
            check({tag, "_wdata"}, bus.wdata,        ewd);
        end
        bus.gnt = 1'b1;
        @(negedge clk);
        bus.gnt = 1'b0;
        check({tag, "_req_drop"}, {31'b0, bus.req}, 32'd0);
        drain({tag, "_drain"});
    endtask

    initial begin
        rst_n      = 1'b0;
        bus.gnt    = 1'b0;
        bus.rvalid = 1'b0;
        bus.rdata  = '0;
        drive_op(1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
        ex_valid   = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_ex_ready", {31'b0, ex_ready}, 32'd1);
        check("rst_bus_req",  {31'b0, bus.req},  32'd0);
        check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        check("rst_bus_be",   {28'b0, bus.be},   32'd0);
        rst_n = 1'b1;

        // lb 0x1003: lane 3 = 0x80 -> sign-extended
        @(negedge clk);
        drive_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_1003, '0);
        expect_wb(32'hFFFF_FF80, 1'b0);
        @(negedge clk);
        load_phase("lb", 30'h400, 4'b1000, 2, 1, 32'h80FF_1234);

        // lhu 0x0002
        @(negedge clk);
        drive_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0002, '0);
        expect_wb(32'h0000_8765, 1'b0);
        @(negedge clk);
        load_phase("lhu", 30'h0, 4'b1100, 1, 0, 32'h8765_4321);

        // lh 0x0004 (signed, low half)
        @(negedge clk);
        drive_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0004, '0);
        expect_wb(32'hFFFF_F00D, 1'b0);
        @(negedge clk);
        load_phase("lh", 30'h1, 4'b0011, 0, 1, 32'h1234_F00D);

        // lbu 0x0009 (lane 1)
        @(negedge clk);
        drive_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0009, '0);
        expect_wb(32'h0000_009A, 1'b0);
        @(negedge clk);
        load_phase("lbu", 30'h2, 4'b0010, 0, 0, 32'h0000_9A00);

        // lw 0x000C, long rvalid wait
        @(negedge clk);
        drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_000C, '0);
        expect_wb(32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        load_phase("lw", 30'h3, 4'b1111, 0, 3, 32'hDEAD_BEEF);

        // read+write both set: handled as a load (size 11 = word)
        @(negedge clk);
        drive_op(1'b1, 1'b1, 2'b11, 1'b0, 32'h0000_0014, 32'hFFFF_FFFF);
        expect_wb(32'h0BAD_CAFE, 1'b0);
        @(negedge clk);
        load_phase("rdwr", 30'h5, 4'b1111, 0, 0, 32'h0BAD_CAFE);

        // neither load nor store: ignored
        @(negedge clk);
        drive_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0040, '0);
        repeat (2) begin
            @(negedge clk);
            check("nop_req",   {31'b0, bus.req},  32'd0);
            check("nop_ready", {31'b0, ex_ready}, 32'd1);
        end
        ex_valid = 1'b0;

        // misaligned lw 0x0006, then sb accepted during its wb pulse
        @(negedge clk);
        drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0006, '0);
        expect_wb(32'h0, 1'b1);
        @(negedge clk);
        check("mis_req",      {31'b0, bus.req},  32'd0);
        check("mis_ready",    {31'b0, ex_ready}, 32'd1);
        check("mis_wb_valid", {31'b0, wb_valid}, 32'd1);
        drive_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'h0000_00AB);
        expect_wb(32'h0, 1'b0);
        @(negedge clk);
        store_phase("sb", 30'h4, 4'b0010, 32'hABAB_ABAB, 2);

        // sh 0x0002
        @(negedge clk);
        drive_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0002, 32'hCAFE_1234);
        expect_wb(32'h0, 1'b0);
        @(negedge clk);
        store_phase("sh", 30'h0, 4'b1100, 32'h1234_1234, 1);

        // sw 0x0100, immediate grant
        @(negedge clk);
        drive_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'h0123_4567);
        expect_wb(32'h0, 1'b0);
        @(negedge clk);
        store_phase("sw", 30'h40, 4'b1111, 32'h0123_4567, 0);

        // misaligned lh 0x0003
        @(negedge clk);
        drive_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0003, '0);
        expect_wb(32'h0, 1'b1);
        @(negedge clk);
        ex_valid = 1'b0;
        check("mis_lh_req", {31'b0, bus.req}, 32'd0);
        drain("mis_lh_drain");

        // reset while in WAIT_R
        @(negedge clk);
        drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0008, '0);
        @(negedge clk);
        ex_valid = 1'b0;
        bus.gnt  = 1'b1;
        @(negedge clk);
        bus.gnt  = 1'b0;
        check("wr_req_drop", {31'b0, bus.req}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_req",    {31'b0, bus.req},  32'd0);
        check("arst_addr",   {2'b0, bus.addr},  32'd0);
        check("arst_be",     {28'b0, bus.be},   32'd0);
        check("arst_we",     {31'b0, bus.we},   32'd0);
        check("arst_wdata",  bus.wdata,         32'd0);
        check("arst_wb",     {30'b0, wb_valid, wb_err}, 32'd0);
        check("arst_wbdata", wb_data,           32'd0);
        check("arst_ready",  {31'b0, ex_ready}, 32'd1);
        @(negedge clk);
        rst_n      = 1'b1;
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h5555_AAAA;
        @(negedge clk);
        bus.rvalid = 1'b0;
        bus.rdata  = '0;
        repeat (2) @(negedge clk);
        check("post_rst_req", {31'b0, bus.req}, 32'd0);
        drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0010, '0);
        expect_wb(32'h1234_5678, 1'b0);
        @(negedge clk);
        load_phase("lw_after_rst", 30'h4, 4'b1111, 1, 1, 32'h1234_5678);

`ifdef LSU_TIMEOUT_EN
        // grant never arrives: abort with error, late grant ignored
        @(negedge clk);
        drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0020, '0);
        expect_wb(32'h0, 1'b1);
        @(negedge clk);
        ex_valid = 1'b0;
        check("tmo_req", {31'b0, bus.req}, 32'd1);
        drain("tmo_drain");
        check("tmo_req_drop", {31'b0, bus.req}, 32'd0);
        bus.gnt = 1'b1;
        @(negedge clk);
        bus.gnt = 1'b0;
        check("tmo_late_gnt", {31'b0, bus.req}, 32'd0);
`endif

        repeat (3) @(negedge clk);
        check("final_outstanding", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access stage between the execute stage and the write-back data selector.
- Takes load/store requests from EX and runs a request/grant/response handshake with the data-memory bus.
- Steers byte lanes for stores; extracts and extends load data.
- Delivers a one-cycle write-back pulse carrying the load word, which feeds the write-back mux's memory-data input.

Parameters:
TIMEOUT_CYCLES, 255, bus-wait limit in cycles (used only with LSU_TIMEOUT_EN); legal range 1..65535

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
ex_valid  input  1  EX presents an operation
ex_ready  output  1  stage can accept; high only in IDLE
ex_mem_read  input  1  operation is a load
ex_mem_write  input  1  operation is a store (read has priority if both set)
ex_size  input  2  00 byte, 01 half, 10 word, 11 treated as word
ex_unsigned  input  1  zero-extend load (lbu/lhu)
ex_addr  input  32  byte address
ex_wdata  input  32  store data, LSB-aligned
bus_req  output  1  bus request, held until bus_gnt
bus_we  output  1  1 = write
bus_addr  output  30  word address (ex_addr[31:2])
bus_be  output  4  byte enables, little-endian lanes
bus_wdata  output  32  lane-replicated store data
bus_gnt  input  1  bus accepted request this cycle
bus_rvalid  input  1  read data valid
bus_rdata  input  32  read word
wb_valid  output  1  one-cycle completion pulse
wb_data  output  32  extended load data; 0 for stores and errors
wb_err  output  1  misaligned access (or timeout), qualified by wb_valid

Behaviour:
- Reset (asynchronous, any state, including mid-transaction): state IDLE; bus_req, bus_we, bus_addr, bus_be, bus_wdata, wb_valid, wb_data, wb_err all 0. ex_ready goes to 1 as IDLE is entered.
- States: IDLE, REQ, WAIT_R.
- Accept: ex_valid & ex_ready & (ex_mem_read | ex_mem_write). Operations that are neither load nor store are ignored; the stage stays in IDLE.
- Misalignment (checked at accept):
  - half with addr[0]=1, or word with addr[1:0]≠0.
  - No bus request is issued; next cycle wb_valid=1, wb_err=1, wb_data=0; state stays IDLE.
- Aligned accept: bus request fields are registered and the stage enters REQ, so bus_req is high the cycle after accept.
- Byte enables: byte = 1<<addr[1:0]; half = addr[1] ? 1100 : 0011; word = 1111.
- Store data: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
- REQ:
  - bus outputs are held stable until bus_gnt.
  - On gnt, a store drops bus_req, pulses wb_valid (wb_data=0, wb_err=0) next cycle, and returns to IDLE.
  - On gnt, a load drops bus_req and enters WAIT_R.
- WAIT_R:
  - On bus_rvalid, select lane by stored addr[1:0], sign- or zero-extend per size/unsigned, register into wb_data, pulse wb_valid next cycle, return to IDLE.
  - Word loads pass through unchanged.
- bus_rvalid is honoured only in WAIT_R; it is ignored in IDLE and REQ. The bus never returns rvalid in the same cycle as gnt.
- Latency:
  - store = 1 + gnt wait + 1 cycles.
  - load = 1 + gnt wait + 1 + rvalid wait cycles.
  - misaligned = 1 cycle.
- Back-to-back: a new accept is allowed in the cycle wb_valid is high (state is already IDLE).
- wb_valid is never high for two consecutive cycles for the same operation.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - A 16-bit counter clears on entering REQ and increments each cycle in REQ/WAIT_R.
  - When the counter reaches TIMEOUT_CYCLES, the stage aborts: bus_req goes to 0, wb_valid=1, wb_err=1, wb_data=0 next cycle, state returns to IDLE.
  - A late gnt or rvalid after the abort is ignored.
  - A completion in the same cycle as the limit is reached wins over the timeout.
- Undefined: no counter; the stage waits indefinitely and TIMEOUT_CYCLES is unused.

Decomposition:
- Package mem_stage_pkg: size encoding constants (SZ_BYTE/SZ_HALF/SZ_WORD), state enum, functions for byte-enable generation and the misalignment check.
- Sub-module load_extend: combinational lane select plus sign/zero extension.
  - Inputs: rdata, addr[1:0], size, unsigned. Output: 32-bit result.
  - Instantiated once; also unit-testable on its own.

Test Plan:
- lb at addr 0x1003, rdata 0x80FF_1234, gnt after 2 cycles, rvalid 1 cycle later -> bus_be=1000, wb_data=0xFFFF_FF80, wb_valid single pulse, wb_err=0.
- lhu at addr 0x0002, rdata 0x8765_4321 -> bus_be=1100, wb_data=0x0000_8765.
- sb at addr 0x0011, wdata 0x0000_00AB -> bus_we=1, bus_addr=0x4, bus_be=0010, bus_wdata=0xABAB_ABAB, held until gnt; wb_valid pulse with wb_data=0.
- lw at addr 0x0006 -> no bus_req, next-cycle wb_valid=1, wb_err=1; a new request is accepted in that same cycle.
- rst_n pulled low while in WAIT_R -> all outputs 0 immediately; a subsequent rvalid is ignored; the next lw completes normally.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, gnt never asserted -> wb_valid with wb_err=1 after the limit, bus_req deasserted.
